b16_to_bcd: RTL and testbench



---
 rtl/b16_to_bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 18 +
 rtl/b16_to_bcd.sv | 75 +++++++
 tb/tb_b16_to_bcd.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/b16_to_bcd_pkg.sv
// Shared widths and types for the 16-bit binary to 5-digit BCD converter.
package b16_to_bcd_pkg;

  localparam int BIN_WIDTH   = 16;
  localparam int NUM_DIGITS  = 5;
  localparam int DIGIT_WIDTH = 4;
  localparam int BCD_WIDTH   = NUM_DIGITS * DIGIT_WIDTH;

  typedef logic [DIGIT_WIDTH-1:0] bcd_digit_t;

  // Threshold at which a nibble is corrected before the next doubling.
  localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;
  localparam bcd_digit_t ADD3_OFFSET    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import b16_to_bcd_pkg::*;
(
  input  logic [DIGIT_WIDTH-1:0] value,
  output logic [DIGIT_WIDTH-1:0] adjusted
);

  // Conditional +3; inputs above 9 never occur inside the network.
  always_comb begin
    adjusted = value;
    if (value >= ADD3_THRESHOLD) begin
      adjusted = value + ADD3_OFFSET;
    end
  end

endmodule

// File: rtl/b16_to_bcd.sv
// Registered 16-bit unsigned binary to five BCD digits (D5 = ten-thousands,
// D1 = units). Combinational double-dabble network, enable mux that blanks
// the display to zeros, and a single output register stage.
module b16_to_bcd
  import b16_to_bcd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIN_WIDTH-1:0]   to_display,
  input  logic                   enable,
  output logic [DIGIT_WIDTH-1:0] D5,
  output logic [DIGIT_WIDTH-1:0] D4,
  output logic [DIGIT_WIDTH-1:0] D3,
  output logic [DIGIT_WIDTH-1:0] D2,
  output logic [DIGIT_WIDTH-1:0] D1
);

  logic [BCD_WIDTH-1:0] converted;
  logic [BCD_WIDTH-1:0] digits_next;
  logic [BCD_WIDTH-1:0] digits_q;

  // The top bit of the adjusted scratch is shifted out every stage; with a
  // 16-bit input it is provably zero, so it is collected here and dropped.
  logic [BIN_WIDTH-1:0] unused_msb;

  // One stage per input bit, MSB first: correct every nibble, then shift the
  // next binary bit in at the bottom.
  for (genvar s = 0; s < BIN_WIDTH; s++) begin : g_stage
    logic [BCD_WIDTH-1:0] prev_bcd;
    logic [BCD_WIDTH-1:0] adj_bcd;
    logic [BCD_WIDTH-1:0] next_bcd;

    if (s == 0) begin : g_first
      assign prev_bcd = '0;
    end else begin : g_chain
      assign prev_bcd = g_stage[s-1].next_bcd;
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      bcd_add3 u_add3 (
        .value    (prev_bcd[d*DIGIT_WIDTH +: DIGIT_WIDTH]),
        .adjusted (adj_bcd[d*DIGIT_WIDTH +: DIGIT_WIDTH])
      );
    end

    assign next_bcd      = {adj_bcd[BCD_WIDTH-2:0], to_display[BIN_WIDTH-1-s]};
    assign unused_msb[s] = adj_bcd[BCD_WIDTH-1];
  end

  assign converted = g_stage[BIN_WIDTH-1].next_bcd;

  // Blank selection; a known-low enable masks any unknown on to_display.
  always_comb begin
    digits_next = '0;
    if (enable) begin
      digits_next = converted;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_next;
    end
  end

  assign D5 = digits_q[4*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign D4 = digits_q[3*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign D3 = digits_q[2*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign D2 = digits_q[1*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign D1 = digits_q[0*DIGIT_WIDTH +: DIGIT_WIDTH];

endmodule

// File: tb/tb_b16_to_bcd.sv
// Directed and random checks for b16_to_bcd. Expected digits are written as
// hex literals whose nibbles read as the decimal value (20'h12345 = 1,2,3,4,5).
module tb_b16_to_bcd;

  logic        clk;
  logic        rst;
  logic [15:0] to_display;
  logic        enable;
  logic [3:0]  D5, D4, D3, D2, D1;

  int n_checks;
  int n_fail;

  b16_to_bcd dut (
    .clk        (clk),
    .rst        (rst),
    .to_display (to_display),
    .enable     (enable),
    .D5         (D5),
    .D4         (D4),
    .D3         (D3),
    .D2         (D2),
    .D1         (D1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] observed();
    return {D5, D4, D3, D2, D1};
  endfunction

  // Reference decimal split by integer division.
  function automatic logic [19:0] ref_split(input logic [15:0] v, input logic en);
    int x;
    logic [19:0] r;
    x = int'(v);
    r = '0;
    if (en) begin
      r[19:16] = 4'(x / 10000);
      r[15:12] = 4'((x / 1000) % 10);
      r[11:8]  = 4'((x / 100) % 10);
      r[7:4]   = 4'((x / 10) % 10);
      r[3:0]   = 4'(x % 10);
    end
    return r;
  endfunction

  task automatic apply_and_clock(input logic [15:0] v, input logic en);
    @(negedge clk);
    to_display = v;
    enable     = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    to_display = 16'd12345;
    enable     = 1'b1;
    #2;
    n_checks++;
    if (observed() !== 20'h00000) begin
      n_fail++;
      $display("FAIL reset_immediate: got %05h expected 00000", observed());
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== 20'h00000) begin
      n_fail++;
      $display("FAIL reset_held: got %05h expected 00000", observed());
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== 20'h12345) begin
      n_fail++;
      $display("FAIL reset_release: got %05h expected 12345", observed());
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] vin [6];
    logic [19:0] vexp [6];
    vin[0] = 16'd0;     vexp[0] = 20'h00000;
    vin[1] = 16'd9;     vexp[1] = 20'h00009;
    vin[2] = 16'd10;    vexp[2] = 20'h00010;
    vin[3] = 16'd65535; vexp[3] = 20'h65535;
    vin[4] = 16'd9999;  vexp[4] = 20'h09999;
    vin[5] = 16'd10000; vexp[5] = 20'h10000;
    for (int i = 0; i < 6; i++) begin
      apply_and_clock(vin[i], 1'b1);
      n_checks++;
      if (observed() !== vexp[i]) begin
        n_fail++;
        $display("FAIL boundary_%0d: got %05h expected %05h", vin[i], observed(), vexp[i]);
      end
    end
    apply_and_clock(16'd42, 1'b1);
    n_checks++;
    if (observed() !== 20'h00042) begin
      n_fail++;
      $display("FAIL no_zero_suppress: got %05h expected 00042", observed());
    end
  endtask

  task automatic test_blanking();
    apply_and_clock(16'd54321, 1'b0);
    n_checks++;
    if (observed() !== 20'h00000) begin
      n_fail++;
      $display("FAIL blank: got %05h expected 00000", observed());
    end
    apply_and_clock(16'd54321, 1'b1);
    n_checks++;
    if (observed() !== 20'h54321) begin
      n_fail++;
      $display("FAIL unblank: got %05h expected 54321", observed());
    end
    apply_and_clock(16'hxxxx, 1'b0);
    n_checks++;
    if (observed() !== 20'h00000) begin
      n_fail++;
      $display("FAIL blank_x_input: got %05h expected 00000", observed());
    end
  endtask

  task automatic test_latency();
    apply_and_clock(16'd100, 1'b1);
    n_checks++;
    if (observed() !== 20'h00100) begin
      n_fail++;
      $display("FAIL latency_first: got %05h expected 00100", observed());
    end
    @(negedge clk);
    to_display = 16'd200;
    #2;
    n_checks++;
    if (observed() !== 20'h00100) begin
      n_fail++;
      $display("FAIL latency_hold: got %05h expected 00100", observed());
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== 20'h00200) begin
      n_fail++;
      $display("FAIL latency_update: got %05h expected 00200", observed());
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic        en;
    logic [19:0] exp_d;
    logic [19:0] got;
    for (int i = 0; i < 100; i++) begin
      v  = 16'($urandom_range(0, 65535));
      en = ($urandom_range(0, 3) != 0);
      apply_and_clock(v, en);
      exp_d = ref_split(v, en);
      got   = observed();
      n_checks++;
      if (got !== exp_d) begin
        n_fail++;
        $display("FAIL random_%0d (in=%0d en=%0b): got %05h expected %05h", i, v, en, got, exp_d);
      end
      n_checks++;
      if (got[19:16] > 4'd6 || got[15:12] > 4'd9 || got[11:8] > 4'd9 ||
          got[7:4] > 4'd9 || got[3:0] > 4'd9) begin
        n_fail++;
        $display("FAIL random_legal_%0d: got %05h expected all digits legal", i, got);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_and_clock(16'd65535, 1'b1);
    n_checks++;
    if (observed() !== 20'h65535) begin
      n_fail++;
      $display("FAIL async_pre: got %05h expected 65535", observed());
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (observed() !== 20'h00000) begin
      n_fail++;
      $display("FAIL async_clear: got %05h expected 00000", observed());
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== 20'h65535) begin
      n_fail++;
      $display("FAIL async_recover: got %05h expected 65535", observed());
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    to_display = '0;
    enable     = 1'b0;
    test_reset();
    test_boundaries();
    test_blanking();
    test_latency();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
